// File: rtl/accelbrot_reg_pkg.sv
`default_nettype none
// =============================================================================
// Package : accelbrot_reg_pkg
// Brief   : Shared types and register offsets for the accelbrot register port.
// Rev     : 1.0  initial release
// =============================================================================
package accelbrot_reg_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_POLL  = 2'd2,
      OP_RSVD  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_OK           = 2'd0,
      ST_RD_TIMEOUT   = 2'd1,
      ST_POLL_TIMEOUT = 2'd2,
      ST_BAD_OP       = 2'd3
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_RWAIT = 3'd3,
      S_GAP   = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   // Register byte offsets shared with the engine
   localparam logic [15:0] STS_BUSY    = 16'h0100;
   localparam logic [15:0] CTL_COMMAND = 16'h0410;

endpackage
`default_nettype wire

// File: rtl/accelbrot_reg_master.sv
`default_nettype none
// =============================================================================
// Module : accelbrot_reg_master
// Brief  : Command-stream initiator for the accelbrot reg_* bus (WRITE/READ/POLL).
// Rev    : 1.0  initial release
// =============================================================================
module accelbrot_reg_master
   import accelbrot_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int RD_TIMEOUT = 64,
   parameter int POLL_GAP   = 8,
   parameter int POLL_LIMIT = 1000000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [DATA_WIDTH-1:0] cmd_mask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_status,
   output logic [ADDR_WIDTH-1:0] reg_address,
   output logic                  reg_write,
   output logic [DATA_WIDTH-1:0] reg_writedata,
   output logic                  reg_read,
   input  logic [DATA_WIDTH-1:0] reg_readdata,
   input  logic                  reg_readdatavalid,
   output logic                  busy
);

   // One down-counter serves both the read timeout and the poll gap
   localparam int                 c_CNT_MAX    = (RD_TIMEOUT > POLL_GAP) ? RD_TIMEOUT : POLL_GAP;
   localparam int                 c_CNT_W      = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
   localparam logic [c_CNT_W-1:0] c_RD_LOAD    = c_CNT_W'((RD_TIMEOUT > 0) ? RD_TIMEOUT - 1 : 0);
   localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
   localparam logic [31:0]        c_POLL_LIMIT = 32'(POLL_LIMIT);

   state_t                r_state,  w_state_nxt;
   logic [c_CNT_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [31:0]           r_reads,  w_reads_nxt;
   op_t                   r_op,     w_op_nxt;
   logic [DATA_WIDTH-1:0] r_mask,   w_mask_nxt;
   logic [DATA_WIDTH-1:0] r_cmp,    w_cmp_nxt;

   logic                  w_cmd_ready_nxt;
   logic                  w_busy_nxt;
   logic                  w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] w_rsp_data_nxt;
   logic [1:0]            w_rsp_status_nxt;
   logic [ADDR_WIDTH-1:0] w_reg_address_nxt;
   logic [DATA_WIDTH-1:0] w_reg_writedata_nxt;
   logic                  w_reg_write_nxt;
   logic                  w_reg_read_nxt;

   logic [31:0]           w_reads_inc;
   logic                  w_hit;
   logic                  w_poll_exhausted;

   assign w_reads_inc      = (&r_reads) ? r_reads : r_reads + 32'd1;
   assign w_hit            = ((reg_readdata ^ r_cmp) & r_mask) == '0;
   assign w_poll_exhausted = (c_POLL_LIMIT != 32'd0) && (w_reads_inc >= c_POLL_LIMIT);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_reads       <= '0;
         r_op          <= OP_WRITE;
         r_mask        <= '0;
         r_cmp         <= '0;
         cmd_ready     <= 1'b0;
         busy          <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_status    <= '0;
         reg_address   <= '0;
         reg_writedata <= '0;
         reg_write     <= 1'b0;
         reg_read      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_reads       <= w_reads_nxt;
         r_op          <= w_op_nxt;
         r_mask        <= w_mask_nxt;
         r_cmp         <= w_cmp_nxt;
         cmd_ready     <= w_cmd_ready_nxt;
         busy          <= w_busy_nxt;
         rsp_valid     <= w_rsp_valid_nxt;
         rsp_data      <= w_rsp_data_nxt;
         rsp_status    <= w_rsp_status_nxt;
         reg_address   <= w_reg_address_nxt;
         reg_writedata <= w_reg_writedata_nxt;
         reg_write     <= w_reg_write_nxt;
         reg_read      <= w_reg_read_nxt;
      end
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_cnt_nxt           = r_cnt;
      w_reads_nxt         = r_reads;
      w_op_nxt            = r_op;
      w_mask_nxt          = r_mask;
      w_cmp_nxt           = r_cmp;
      w_rsp_valid_nxt     = rsp_valid;
      w_rsp_data_nxt      = rsp_data;
      w_rsp_status_nxt    = rsp_status;
      w_reg_address_nxt   = reg_address;
      w_reg_writedata_nxt = reg_writedata;
      w_reg_write_nxt     = 1'b0;
      w_reg_read_nxt      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               w_op_nxt    = op_t'(cmd_op);
               w_mask_nxt  = cmd_mask;
               w_cmp_nxt   = cmd_data;
               w_reads_nxt = '0;
               case (op_t'(cmd_op))
                  OP_WRITE: begin
                     w_reg_address_nxt   = cmd_addr;
                     w_reg_writedata_nxt = cmd_data;
                     w_reg_write_nxt     = 1'b1;
                     w_state_nxt         = S_WR;
                  end
                  OP_READ, OP_POLL: begin
                     w_reg_address_nxt = cmd_addr;
                     w_reg_read_nxt    = 1'b1;
                     w_cnt_nxt         = c_RD_LOAD;
                     w_state_nxt       = S_RD;
                  end
                  default: begin
                     w_rsp_valid_nxt  = 1'b1;
                     w_rsp_data_nxt   = '0;
                     w_rsp_status_nxt = ST_BAD_OP;
                     w_state_nxt      = S_RESP;
                  end
               endcase
            end
         end

         S_WR: begin
            w_rsp_valid_nxt  = 1'b1;
            w_rsp_data_nxt   = '0;
            w_rsp_status_nxt = ST_OK;
            w_state_nxt      = S_RESP;
         end

         S_RD: w_state_nxt = S_RWAIT;

         S_RWAIT: begin
            // Valid data takes priority over an expiring timeout in the same cycle
            if (reg_readdatavalid) begin
               w_rsp_data_nxt = reg_readdata;
               if (r_op == OP_READ || w_hit) begin
                  w_rsp_valid_nxt  = 1'b1;
                  w_rsp_status_nxt = ST_OK;
                  w_state_nxt      = S_RESP;
               end else if (w_poll_exhausted) begin
                  w_rsp_valid_nxt  = 1'b1;
                  w_rsp_status_nxt = ST_POLL_TIMEOUT;
                  w_state_nxt      = S_RESP;
               end else if (POLL_GAP == 0) begin
                  w_reg_read_nxt = 1'b1;
                  w_cnt_nxt      = c_RD_LOAD;
                  w_state_nxt    = S_RD;
               end else begin
                  w_cnt_nxt   = c_GAP_LOAD;
                  w_state_nxt = S_GAP;
               end
               w_reads_nxt = w_reads_inc;
            end else if (r_cnt == '0) begin
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_data_nxt   = '0;
               w_rsp_status_nxt = ST_RD_TIMEOUT;
               w_state_nxt      = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end

         S_GAP: begin
            if (r_cnt == '0) begin
               w_reg_read_nxt = 1'b1;
               w_cnt_nxt      = c_RD_LOAD;
               w_state_nxt    = S_RD;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase

      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_accelbrot_reg_master.sv
`default_nettype none
// =============================================================================
// Module : tb_accelbrot_reg_master
// Brief  : Randomized self-checking bench with an engine responder and reference model.
// Rev    : 1.0  initial release
// =============================================================================
module tb_accelbrot_reg_master;
   import accelbrot_reg_pkg::*;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int RD_TO = 64;
   localparam int GAP   = 8;
   localparam int PLIM  = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0]    cmd_op, rsp_status;
   logic [AW-1:0] cmd_addr, reg_address;
   logic [DW-1:0] cmd_data, cmd_mask, rsp_data, reg_writedata, reg_readdata;
   logic          reg_write, reg_read, reg_readdatavalid, busy;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   accelbrot_reg_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RD_TO), .POLL_GAP(GAP), .POLL_LIMIT(PLIM)
   ) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
      .reg_address(reg_address), .reg_write(reg_write), .reg_writedata(reg_writedata),
      .reg_read(reg_read), .reg_readdata(reg_readdata), .reg_readdatavalid(reg_readdatavalid),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine responder plan (delay after strobe, data) and bus monitor records
   int          plan_d[$];
   logic [31:0] plan_v[$];
   int          rd_cyc_q[$];
   logic [15:0] rd_addr_q[$];
   int          wr_cyc_q[$];
   logic [15:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          overlap_cnt = 0;
   int          wide_cnt    = 0;
   bit          stray_req   = 0;

   initial begin : responder
      bit          pend, prev_rd, prev_wr;
      int          pend_cyc, d;
      logic [31:0] pend_val;
      pend = 0; prev_rd = 0; prev_wr = 0; pend_cyc = 0; pend_val = '0;
      reg_readdatavalid = 1'b0;
      reg_readdata      = '0;
      forever begin
         @(negedge clk);
         reg_readdatavalid = 1'b0;
         reg_readdata      = $urandom;
         if (stray_req) begin
            reg_readdatavalid = 1'b1;
            stray_req         = 0;
         end
         if (pend && cyc == pend_cyc) begin
            reg_readdatavalid = 1'b1;
            reg_readdata      = pend_val;
            pend              = 0;
         end
         if (reg_read === 1'b1 && reg_write === 1'b1) overlap_cnt++;
         if ((reg_read === 1'b1 && prev_rd) || (reg_write === 1'b1 && prev_wr)) wide_cnt++;
         prev_rd = (reg_read === 1'b1);
         prev_wr = (reg_write === 1'b1);
         if (reg_write === 1'b1) begin
            wr_cyc_q.push_back(cyc); wr_addr_q.push_back(reg_address); wr_data_q.push_back(reg_writedata);
         end
         if (reg_read === 1'b1) begin
            rd_cyc_q.push_back(cyc); rd_addr_q.push_back(reg_address);
            if (plan_d.size() > 0) begin
               d = plan_d.pop_front();
               pend_val = plan_v.pop_front();
               if (d > 0) begin pend = 1; pend_cyc = cyc + d; end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

   task automatic clear_mon();
      rd_cyc_q.delete(); rd_addr_q.delete();
      wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
      plan_d.delete(); plan_v.delete();
   endtask

   // Issues one command, waits for its response and consumes it immediately
   task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, output logic [1:0] st, output logic [31:0] rdat,
                         output int acc, output int rc);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (cmd_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL cmd_accept: got cmd_ready=%b expected 1 within 50 cycles", cmd_ready);
      end
      acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
      cmd_data = $urandom; cmd_mask = $urandom;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (rsp_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL rsp_wait: got rsp_valid=%b expected 1 within 500 cycles", rsp_valid);
      end
      rc = cyc; st = rsp_status; rdat = rsp_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // POLL reference: walk the planned reads applying the hit / limit / timeout rules
   function automatic void poll_model(input logic [31:0] mask, input logic [31:0] cmp,
                                      input int pd[4], input logic [31:0] pv[4],
                                      output int n, output logic [1:0] st, output logic [31:0] dat,
                                      output int lat);
      n = 0; st = ST_POLL_TIMEOUT; dat = '0; lat = 1;
      for (int i = 0; i < 4; i++) begin
         n = i + 1;
         if (pd[i] < 1 || pd[i] > RD_TO) begin
            st = ST_RD_TIMEOUT; dat = '0; lat += RD_TO + 1; return;
         end
         dat = pv[i];
         if ((pv[i] & mask) == (cmp & mask)) begin st = ST_OK; lat += pd[i] + 1; return; end
         if (n >= PLIM) begin st = ST_POLL_TIMEOUT; lat += pd[i] + 1; return; end
         lat += pd[i] + 1 + GAP;
      end
   endfunction

   task automatic test_reset();
      rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_status, reg_address, reg_write, reg_writedata,
           reg_read, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b rv=%b rd=%h st=%0d a=%h w=%b wd=%h r=%b busy=%b expected all 0",
                  cmd_ready, rsp_valid, rsp_data, rsp_status, reg_address, reg_write, reg_writedata, reg_read, busy);
      end
      rstn = 1'b1;
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", cmd_ready); end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_ready_rise: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_write();
      logic [15:0] addr; logic [31:0] data, rd; logic [1:0] st; int acc, rc;
      for (int i = 0; i < 5; i++) begin
         addr = (i == 0) ? 16'h0420 : 16'($urandom);
         data = (i == 0) ? 32'h0000_1000 : $urandom;
         clear_mon();
         do_cmd(OP_WRITE, addr, data, $urandom, st, rd, acc, rc);
         checks++;
         if (wr_cyc_q.size() != 1 || rd_cyc_q.size() != 0 || wr_cyc_q[0] != acc + 1 ||
             wr_addr_q[0] !== addr || wr_data_q[0] !== data) begin
            errors++;
            $display("FAIL write_strobe[%0d]: got %0d writes %0d reads cyc=%0d a=%h d=%h expected 1 0 cyc=%0d a=%h d=%h",
                     i, wr_cyc_q.size(), rd_cyc_q.size(), wr_cyc_q[0] - acc, wr_addr_q[0], wr_data_q[0], 1, addr, data);
         end
         checks++;
         if (st !== ST_OK || rd !== '0 || rc != acc + 2) begin
            errors++;
            $display("FAIL write_rsp[%0d]: got st=%0d data=%h lat=%0d expected 0 0 2", i, st, rd, rc - acc);
         end
         checks++;
         if (reg_address !== addr || reg_writedata !== data) begin
            errors++;
            $display("FAIL write_hold[%0d]: got a=%h d=%h expected a=%h d=%h", i, reg_address, reg_writedata, addr, data);
         end
      end
   endtask

   task automatic test_read();
      logic [15:0] addr; logic [31:0] v, rd, exp_d; logic [1:0] st, exp_st; int acc, rc, d, exp_lat;
      for (int i = 0; i < 8; i++) begin
         addr = (i == 0) ? 16'h0130 : 16'($urandom);
         v    = (i == 0) ? 32'hDEAD_BEEF : $urandom;
         case (i)
            0:       d = 3;
            1:       d = RD_TO;
            2:       d = -1;
            3:       d = RD_TO + 1;
            default: d = $urandom_range(1, 20);
         endcase
         if (i == 4) begin stray_req = 1; repeat (3) @(negedge clk); end
         if (d >= 1 && d <= RD_TO) begin exp_st = ST_OK; exp_d = v; exp_lat = d + 2; end
         else begin exp_st = ST_RD_TIMEOUT; exp_d = '0; exp_lat = RD_TO + 2; end
         clear_mon();
         plan_d.push_back(d); plan_v.push_back(v);
         do_cmd(OP_READ, addr, $urandom, $urandom, st, rd, acc, rc);
         checks++;
         if (rd_cyc_q.size() != 1 || wr_cyc_q.size() != 0 || rd_cyc_q[0] != acc + 1 || rd_addr_q[0] !== addr) begin
            errors++;
            $display("FAIL read_strobe[%0d]: got %0d reads %0d writes cyc=%0d a=%h expected 1 0 cyc=1 a=%h",
                     i, rd_cyc_q.size(), wr_cyc_q.size(), rd_cyc_q[0] - acc, rd_addr_q[0], addr);
         end
         checks++;
         if (st !== exp_st || rd !== exp_d || rc != acc + exp_lat) begin
            errors++;
            $display("FAIL read_rsp[%0d] d=%0d: got st=%0d data=%h lat=%0d expected st=%0d data=%h lat=%0d",
                     i, d, st, rd, rc - acc, exp_st, exp_d, exp_lat);
         end
      end
   endtask

   task automatic test_poll();
      logic [15:0] addr; logic [31:0] mask, cmp, rd, exp_d; logic [1:0] st, exp_st;
      int acc, rc, exp_n, exp_lat; int pd[4]; logic [31:0] pv[4]; bit bad;
      for (int it = 0; it < 9; it++) begin
         addr = (it == 0) ? STS_BUSY : 16'($urandom);
         mask = (it < 2 || $urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
         cmp  = (it == 0) ? 32'h0 : $urandom;
         for (int i = 0; i < 4; i++) begin
            pd[i] = ($urandom_range(0, 9) == 0) ? RD_TO : $urandom_range(1, 6);
            if (it >= 2 && $urandom_range(0, 11) == 0) pd[i] = -1;
            if (it == 0)      pv[i] = (i < 2) ? 32'h1 : 32'h0;
            else if (it == 1) pv[i] = cmp ^ (32'h1 << i);
            else              pv[i] = ($urandom_range(0, 2) == 0) ? ((cmp & mask) | ($urandom & ~mask)) : $urandom;
         end
         poll_model(mask, cmp, pd, pv, exp_n, exp_st, exp_d, exp_lat);
         clear_mon();
         for (int i = 0; i < 4; i++) begin plan_d.push_back(pd[i]); plan_v.push_back(pv[i]); end
         do_cmd(OP_POLL, addr, cmp, mask, st, rd, acc, rc);
         checks++;
         if (rd_cyc_q.size() != exp_n || wr_cyc_q.size() != 0 || rd_cyc_q[0] != acc + 1) begin
            errors++;
            $display("FAIL poll_strobes[%0d]: got %0d reads first=%0d writes=%0d expected %0d reads first=1 writes=0",
                     it, rd_cyc_q.size(), rd_cyc_q[0] - acc, wr_cyc_q.size(), exp_n);
         end
         bad = 0;
         for (int j = 0; j < rd_cyc_q.size(); j++) begin
            if (rd_addr_q[j] !== addr) bad = 1;
            if (j > 0 && j < 4 && rd_cyc_q[j] - rd_cyc_q[j-1] != 1 + pd[j-1] + GAP) bad = 1;
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL poll_spacing[%0d]: got strobe spacing/address mismatch expected spacing 1+delay+%0d at a=%h",
                     it, GAP, addr);
         end
         checks++;
         if (st !== exp_st || rd !== exp_d || rc != acc + exp_lat) begin
            errors++;
            $display("FAIL poll_rsp[%0d]: got st=%0d data=%h lat=%0d expected st=%0d data=%h lat=%0d",
                     it, st, rd, rc - acc, exp_st, exp_d, exp_lat);
         end
      end
   endtask

   task automatic test_bad_op();
      logic [31:0] rd; logic [1:0] st; int acc, rc;
      for (int i = 0; i < 2; i++) begin
         clear_mon();
         do_cmd(OP_RSVD, 16'($urandom), $urandom, $urandom, st, rd, acc, rc);
         checks++;
         if (st !== ST_BAD_OP || rd !== '0 || rc != acc + 1 || rd_cyc_q.size() != 0 || wr_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL bad_op[%0d]: got st=%0d data=%h lat=%0d reads=%0d writes=%0d expected 3 0 1 0 0",
                     i, st, rd, rc - acc, rd_cyc_q.size(), wr_cyc_q.size());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] v, d0; logic [1:0] s0; int n; bit bad;
      clear_mon();
      v = $urandom;
      plan_d.push_back(2); plan_v.push_back(v);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = CTL_COMMAND;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      d0 = rsp_data; s0 = rsp_status;
      checks++;
      if (rsp_valid !== 1'b1 || d0 !== v || s0 !== ST_OK) begin
         errors++; $display("FAIL bp_rsp: got rv=%b data=%h st=%0d expected 1 %h 0", rsp_valid, d0, s0, v);
      end
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_status !== s0 || cmd_ready !== 1'b0 || busy !== 1'b1)
            bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bp_hold: got rv=%b data=%h st=%0d ready=%b busy=%b expected stable 1 %h %0d 0 1",
                  rsp_valid, rsp_data, rsp_status, cmd_ready, busy, d0, s0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release: got ready=%b rv=%b busy=%b expected 1 0 0", cmd_ready, rsp_valid, busy);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] v, rd; logic [1:0] st; int n, acc, rc; bit bad;
      clear_mon();
      plan_d.push_back(6); plan_v.push_back($urandom);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 16'h0130;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_status, reg_address, reg_write, reg_writedata,
           reg_read, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got ready=%b rv=%b rd=%h a=%h r=%b busy=%b expected all 0",
                  cmd_ready, rsp_valid, rsp_data, reg_address, reg_read, busy);
      end
      rstn = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || reg_read !== 1'b0 || reg_write !== 1'b0) bad = 1;
      end
      checks++;
      if (bad || rd_cyc_q.size() != 1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_quiet: got activity=%b reads=%0d ready=%b busy=%b expected 0 1 1 0",
                  bad, rd_cyc_q.size(), cmd_ready, busy);
      end
      clear_mon();
      v = $urandom;
      plan_d.push_back(2); plan_v.push_back(v);
      do_cmd(OP_READ, 16'h0130, '0, '0, st, rd, acc, rc);
      checks++;
      if (st !== ST_OK || rd !== v || rc != acc + 4) begin
         errors++;
         $display("FAIL midreset_recover: got st=%0d data=%h lat=%0d expected 0 %h 4", st, rd, rc - acc, v);
      end
   endtask

   initial begin : main
      test_reset();
      test_write();
      test_read();
      test_poll();
      test_bad_op();
      test_backpressure();
      test_reset_mid_read();
      checks++;
      if (overlap_cnt != 0 || wide_cnt != 0) begin
         errors++;
         $display("FAIL strobe_shape: got overlap=%0d wide=%0d expected 0 0", overlap_cnt, wide_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
